// File: rtl/imuldiv_mul_iterative_param.sv
// imuldiv_mul_iterative_param
//   Iterative shift-add multiplier with a parametrised operand width. Each
//   request selects signed or unsigned mode. The datapath works on operand
//   magnitudes only, and the product sign is applied at the output. With
//   EARLY_EXIT=1 the calculation stops as soon as no multiplier bits remain.
//
// Ports
//   clk                 clock, rising edge
//   reset               asynchronous, active-high; clears all state
//   mulreq_msg_a        multiplicand (W bits)
//   mulreq_msg_b        multiplier (W bits)
//   mulreq_msg_signed   1 = two's-complement operands, 0 = unsigned
//   mulreq_val/rdy      request handshake
//   mulresp_msg_result  product (2*W bits)
//   mulresp_val/rdy     response handshake
module imuldiv_mul_iterative_param #(
  parameter int W          = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   mulreq_msg_a,
  input  logic [W-1:0]   mulreq_msg_b,
  input  logic           mulreq_msg_signed,
  input  logic           mulreq_val,
  output logic           mulreq_rdy,
  output logic [2*W-1:0] mulresp_msg_result,
  output logic           mulresp_val,
  input  logic           mulresp_rdy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  a_reg;
  logic [W-1:0]    b_reg;
  logic [2*W-1:0]  result;
  logic            neg;

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            fire;
  logic            last_step;

  // Two's-complement magnitude. Applied to the most-negative value, this
  // yields 2^(W-1), which is still correct when read as an unsigned W-bit value.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
    if (sgn && x[W-1]) begin
      return ~x + {{(W-1){1'b0}}, 1'b1};
    end else begin
      return x;
    end
  endfunction

  // Request decode, operand magnitudes and the termination condition for CALC
  always_comb begin
    fire      = mulreq_val && (state == IDLE);
    a_mag     = magnitude(mulreq_msg_a, mulreq_msg_signed);
    b_mag     = magnitude(mulreq_msg_b, mulreq_msg_signed);
    // EARLY_EXIT stops once the multiplier bits left after this step are all zero
    last_step = (count == CW'(W-1)) ||
                (EARLY_EXIT && ((b_reg >> 1) == {W{1'b0}}));
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fire) state_next = CALC;
        else      state_next = IDLE;
      end
      CALC: begin
        if (last_step) state_next = DONE;
        else           state_next = CALC;
      end
      DONE: begin
        if (mulresp_rdy) state_next = IDLE;
        else             state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath registers: operand capture in IDLE, one shift-add step per cycle in CALC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            count  <= '0;
            a_reg  <= {{W{1'b0}}, a_mag};
            b_reg  <= b_mag;
            result <= '0;
            neg    <= mulreq_msg_signed & (mulreq_msg_a[W-1] ^ mulreq_msg_b[W-1]);
          end
        end
        CALC: begin
          if (b_reg[0]) result <= result + a_reg;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          count <= count + CW'(1);
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Outputs derive only from registered state. Negating a zero result gives
  // zero again, so a negative zero cannot appear.
  always_comb begin
    mulreq_rdy         = (state == IDLE);
    mulresp_val        = (state == DONE);
    mulresp_msg_result = neg ? (~result + {{(2*W-1){1'b0}}, 1'b1}) : result;
  end

endmodule
